// File: rtl/bus_responder_if.sv
// bus_responder_if
// CPU-side bus bundle between the 6502 core and its memory responder.
//   i_addr  : CPU address, held while o_ready is low
//   i_dout  : CPU write data
//   i_rwbar : 1 = read, 0 = write
//   i_sync  : opcode-fetch cycle marker
//   o_din   : read data returned to the CPU
//   o_ready : bus cycle completes at the coming rising edge
// Modports: master = CPU side, slave = responder side.
interface bus_responder_if;
  logic [15:0] i_addr;
  logic [7:0]  i_dout;
  logic        i_rwbar;
  logic        i_sync;
  logic [7:0]  o_din;
  logic        o_ready;

  modport master (
    output i_addr, i_dout, i_rwbar, i_sync,
    input  o_din, o_ready
  );

  modport slave (
    input  i_addr, i_dout, i_rwbar, i_sync,
    output o_din, o_ready
  );
endinterface

// File: rtl/bus_responder.sv
// bus_responder
// Memory-side responder for the 6502 external bus: RAM, vector bytes and a
// small MMIO block, with per-access-type wait states throttling READY.
// Ports:
//   i_clk, i_rst_n : clock (rising edge), async active-low reset
//   bus            : CPU bus bundle (slave side)
//   o_port         : MMIO output port register (0xF000)
//   o_port_stb     : 1-cycle pulse after a port write commits
//   o_bus_err      : 1-cycle pulse after a dropped (unmapped/read-only) write
//   i_ld_en/i_ld_addr/i_ld_data : bench preload into RAM, wins on collision
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FIRST | first cycle of a bus cycle; wait count chosen from access type
// ST_HOLD  | inserting wait states; completes when cnt_q reaches zero
module bus_responder #(
  parameter int          RAM_AW     = 12,
  parameter int          WAIT_FETCH = 1,
  parameter int          WAIT_RD    = 0,
  parameter int          WAIT_WR    = 0,
  parameter logic [15:0] RESET_VEC  = 16'h0200,
  parameter logic [15:0] NMI_VEC    = 16'h0300,
  parameter logic [15:0] IRQ_VEC    = 16'h0400
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  bus_responder_if.slave    bus,
  output logic [7:0]        o_port,
  output logic              o_port_stb,
  output logic              o_bus_err,
  input  logic              i_ld_en,
  input  logic [RAM_AW-1:0] i_ld_addr,
  input  logic [7:0]        i_ld_data
);

  localparam int WMAX_A = (WAIT_FETCH > WAIT_RD) ? WAIT_FETCH : WAIT_RD;
  localparam int WMAX   = (WMAX_A > WAIT_WR) ? WMAX_A : WAIT_WR;
  localparam int CW     = (WMAX > 0) ? $clog2(WMAX + 1) : 1;

  typedef enum logic {ST_FIRST, ST_HOLD} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      port_q;
  logic            port_stb_q;
  logic            bus_err_q;
  logic [7:0]      cyc_q;
  logic [7:0]      ram_q [2**RAM_AW];

  logic [CW-1:0]   w_sel;
  logic            ready;
  logic            wr_commit;
  logic            is_ram;
  logic            is_port;
  logic [7:0]      rd_data;

  assign w_sel = (bus.i_rwbar && bus.i_sync) ? CW'(WAIT_FETCH) :
                 bus.i_rwbar                 ? CW'(WAIT_RD)    : CW'(WAIT_WR);

  // READY is combinational so zero-wait accesses complete in their first
  // cycle; reset forces it low so an in-flight write can never commit.
  assign ready = i_rst_n &&
                 (((state_q == ST_FIRST) && (w_sel == '0)) ||
                  ((state_q == ST_HOLD)  && (cnt_q == '0)));

  assign wr_commit = ready && !bus.i_rwbar;
  assign is_ram    = ((bus.i_addr >> RAM_AW) == 16'd0);
  assign is_port   = (bus.i_addr == 16'hF000);

  always_comb begin
    rd_data = 8'hFF;
    if (is_ram) begin
      rd_data = ram_q[bus.i_addr[RAM_AW-1:0]];
    end else begin
      case (bus.i_addr)
        16'hF000: rd_data = port_q;
        16'hF001: rd_data = cyc_q;
        16'hFFFA: rd_data = NMI_VEC[7:0];
        16'hFFFB: rd_data = NMI_VEC[15:8];
        16'hFFFC: rd_data = RESET_VEC[7:0];
        16'hFFFD: rd_data = RESET_VEC[15:8];
        16'hFFFE: rd_data = IRQ_VEC[7:0];
        16'hFFFF: rd_data = IRQ_VEC[15:8];
        default:  rd_data = 8'hFF;
      endcase
    end
  end

  assign bus.o_din   = ready ? rd_data : 8'hFF;
  assign bus.o_ready = ready;
  assign o_port      = port_q;
  assign o_port_stb  = port_stb_q;
  assign o_bus_err   = bus_err_q;

  // RAM is deliberately outside reset. The preload assignment comes last so
  // it overrides a CPU write to the same address on the same edge.
  always_ff @(posedge i_clk) begin
    if (wr_commit && is_ram) begin
      ram_q[bus.i_addr[RAM_AW-1:0]] <= bus.i_dout;
    end
    if (i_ld_en) begin
      ram_q[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_FIRST;
      cnt_q      <= '0;
      port_q     <= 8'h00;
      port_stb_q <= 1'b0;
      bus_err_q  <= 1'b0;
      cyc_q      <= 8'h00;
    end else begin
      cyc_q      <= cyc_q + 8'd1;
      port_stb_q <= wr_commit && is_port;
      bus_err_q  <= wr_commit && !(is_ram || is_port);
      if (wr_commit && is_port) begin
        port_q <= bus.i_dout;
      end
      case (state_q)
        ST_FIRST: begin
          if (w_sel != '0) begin
            cnt_q   <= w_sel - CW'(1);
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= ST_FIRST;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;

  // Three responders with different wait-state mixes; only the selected one
  // is out of reset, the others are parked in reset.
  localparam logic [15:0] RV = 16'h0200;
  localparam logic [15:0] NV = 16'h0300;
  localparam logic [15:0] IV = 16'h0400;

  logic        clk = 1'b0;
  logic        rst_n_g;
  int          sel;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        rwbar, sync;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;

  always #5 clk = ~clk;

  bus_responder_if bif0 ();
  bus_responder_if bif1 ();
  bus_responder_if bif2 ();

  assign bif0.i_addr = addr;  assign bif0.i_dout = dout;
  assign bif0.i_rwbar = rwbar; assign bif0.i_sync = sync;
  assign bif1.i_addr = addr;  assign bif1.i_dout = dout;
  assign bif1.i_rwbar = rwbar; assign bif1.i_sync = sync;
  assign bif2.i_addr = addr;  assign bif2.i_dout = dout;
  assign bif2.i_rwbar = rwbar; assign bif2.i_sync = sync;

  logic [7:0] port0, port1, port2;
  logic       stb0, stb1, stb2, err0, err1, err2;

  bus_responder dut_a (
    .i_clk(clk), .i_rst_n(rst_n_g && sel == 0), .bus(bif0),
    .o_port(port0), .o_port_stb(stb0), .o_bus_err(err0),
    .i_ld_en(ld_en && sel == 0), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  bus_responder #(.WAIT_FETCH(3), .WAIT_RD(1), .WAIT_WR(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n_g && sel == 1), .bus(bif1),
    .o_port(port1), .o_port_stb(stb1), .o_bus_err(err1),
    .i_ld_en(ld_en && sel == 1), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  bus_responder #(.WAIT_FETCH(2), .WAIT_RD(0), .WAIT_WR(2)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n_g && sel == 2), .bus(bif2),
    .o_port(port2), .o_port_stb(stb2), .o_bus_err(err2),
    .i_ld_en(ld_en && sel == 2), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  logic [7:0] din_s, port_s;
  logic       rdy_s, stb_s, err_s;

  always_comb begin
    din_s = bif0.o_din; rdy_s = bif0.o_ready; port_s = port0; stb_s = stb0; err_s = err0;
    if (sel == 1) begin
      din_s = bif1.o_din; rdy_s = bif1.o_ready; port_s = port1; stb_s = stb1; err_s = err1;
    end else if (sel == 2) begin
      din_s = bif2.o_din; rdy_s = bif2.o_ready; port_s = port2; stb_s = stb2; err_s = err2;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] mram [3][4096];
  logic [7:0] mport;
  logic [7:0] mcnt;
  logic       exp_stb, exp_err;
  int         total = 0;
  int         bad = 0;

  always @(posedge clk or negedge rst_n_g)
    if (!rst_n_g) mcnt <= 8'h00;
    else          mcnt <= mcnt + 8'd1;

  function automatic int wait_of(input int k, input logic rw, input logic sy);
    int f, r, w;
    f = (k == 0) ? 1 : (k == 1) ? 3 : 2;
    r = (k == 1) ? 1 : 0;
    w = (k == 0) ? 0 : (k == 1) ? 3 : 2;
    if (rw && sy) return f;
    if (rw) return r;
    return w;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (a < 16'h1000) return mram[sel][a[11:0]];
    if (a == 16'hF000) return mport;
    if (a == 16'hF001) return mcnt;
    if (a == 16'hFFFA) return NV[7:0];
    if (a == 16'hFFFB) return NV[15:8];
    if (a == 16'hFFFC) return RV[7:0];
    if (a == 16'hFFFD) return RV[15:8];
    if (a == 16'hFFFE) return IV[7:0];
    if (a == 16'hFFFF) return IV[15:8];
    return 8'hFF;
  endfunction

  function automatic logic [7:0] peek(input int k, input logic [11:0] a);
    if (k == 0) return dut_a.ram_q[a];
    if (k == 1) return dut_b.ram_q[a];
    return dut_c.ram_q[a];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete bus cycle, entered and left on a falling edge. abort_at >= 0
  // asserts reset right after sampling that cycle index and returns.
  task automatic bus(input logic [15:0] a, input logic rw, input logic sy,
                     input logic [7:0] d, input int abort_at);
    int  w;
    bit  done, is_ram, is_port;
    w = wait_of(sel, rw, sy);
    is_ram  = (a < 16'h1000);
    is_port = (a == 16'hF000);
    addr = a; rwbar = rw; sync = sy; dout = d;
    for (int c = 0; c <= w; c++) begin
      done = (c == w);
      #1;
      chk($sformatf("ready@%h c%0d", a, c), {7'd0, rdy_s}, {7'd0, done});
      if (rw) chk($sformatf("din@%h c%0d", a, c), din_s, done ? exp_rd(a) : 8'hFF);
      chk($sformatf("stb@%h c%0d", a, c), {7'd0, stb_s}, {7'd0, exp_stb});
      chk($sformatf("err@%h c%0d", a, c), {7'd0, err_s}, {7'd0, exp_err});
      chk($sformatf("port@%h c%0d", a, c), port_s, mport);
      if (c == abort_at) begin
        rst_n_g = 1'b0;
        #1;
        chk("rst_ready", {7'd0, rdy_s}, 8'h00);
        chk("rst_din", din_s, 8'hFF);
        chk("rst_port", port_s, 8'h00);
        mport = 8'h00; exp_stb = 1'b0; exp_err = 1'b0;
        return;
      end
      @(posedge clk);
      if (done && !rw) begin
        if (is_ram) mram[sel][a[11:0]] = d;
        else if (is_port) mport = d;
      end
      if (ld_en) mram[sel][ld_addr] = ld_data;
      exp_stb = done && !rw && is_port;
      exp_err = done && !rw && !is_ram && !is_port;
      if (!rw && is_ram) begin
        #1;
        chk($sformatf("ram@%h c%0d", a, c), peek(sel, a[11:0]), mram[sel][a[11:0]]);
      end
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk);
    mram[sel][a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic start_dut(input int k);
    rst_n_g = 1'b0; sel = k; ld_en = 1'b0;
    addr = 16'hFFFC; rwbar = 1'b1; sync = 1'b0; dout = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(12'(i), 8'($urandom));
    for (int i = 0; i < 64; i++) preload(12'(16'h200 + i), 8'($urandom));
    preload(12'h200, 8'hA9);
    preload(12'h020, 8'h11);
    #1;
    chk("reset_ready", {7'd0, rdy_s}, 8'h00);
    chk("reset_din", din_s, 8'hFF);
    chk("reset_port", port_s, 8'h00);
    chk("reset_stb", {7'd0, stb_s}, 8'h00);
    chk("reset_err", {7'd0, err_s}, 8'h00);
    mport = 8'h00; exp_stb = 1'b0; exp_err = 1'b0;
    rst_n_g = 1'b1;
  endtask

  task automatic random_phase(input int n);
    logic [15:0] a;
    logic        rw, sy;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = 16'($urandom_range(0, 63));
        2:       a = 16'(16'h200 + $urandom_range(0, 63));
        3:       a = 16'hF000;
        4:       a = 16'hF001;
        5:       a = 16'(16'hFFFA + $urandom_range(0, 5));
        6:       a = 16'(16'h1000 + $urandom_range(0, 16'hDFFF));
        default: a = 16'(16'hF002 + $urandom_range(0, 16'h0FF7));
      endcase
      rw = 1'($urandom_range(0, 1));
      sy = rw ? 1'($urandom_range(0, 1)) : 1'b0;
      bus(a, rw, sy, 8'($urandom), -1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_g = 1'b0; sel = 0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    addr = 16'hFFFC; rwbar = 1'b1; sync = 1'b0; dout = 8'h00;

    // defaults: fetch 1, read 0, write 0
    start_dut(0);
    bus(16'hFFFC, 1'b1, 1'b0, 8'h00, -1);
    bus(16'hFFFD, 1'b1, 1'b0, 8'h00, -1);
    bus(16'h0200, 1'b1, 1'b1, 8'h00, -1);
    bus(16'hF000, 1'b0, 1'b0, 8'h3C, -1);
    bus(16'hF000, 1'b1, 1'b0, 8'h00, -1);
    bus(16'h8000, 1'b0, 1'b0, 8'hE7, -1);
    bus(16'h8000, 1'b1, 1'b0, 8'h00, -1);
    bus(16'hF001, 1'b1, 1'b0, 8'h00, -1);
    ld_addr = 12'h030; ld_data = 8'h77; ld_en = 1'b1;
    bus(16'h0030, 1'b0, 1'b0, 8'h99, -1);
    ld_en = 1'b0;
    bus(16'h0030, 1'b1, 1'b0, 8'h00, -1);
    bus(16'h0011, 1'b0, 1'b0, 8'hC3, -1);
    bus(16'h0011, 1'b1, 1'b0, 8'h00, -1);
    random_phase(60);

    // fetch 3, read 1, write 3: long fetch and reset in the middle of a write
    start_dut(1);
    bus(16'h0200, 1'b1, 1'b1, 8'h00, -1);
    bus(16'hFFFC, 1'b1, 1'b0, 8'h00, -1);
    bus(16'hF000, 1'b0, 1'b0, 8'h3C, -1);
    bus(16'hF000, 1'b1, 1'b0, 8'h00, -1);
    bus(16'h0020, 1'b0, 1'b0, 8'h5A, 2);
    repeat (2) @(negedge clk);
    rst_n_g = 1'b1;
    bus(16'h0020, 1'b1, 1'b0, 8'h00, -1);
    bus(16'hF000, 1'b1, 1'b0, 8'h00, -1);
    random_phase(60);

    // fetch 2, read 0, write 2: write/readback with wait states
    start_dut(2);
    bus(16'h0010, 1'b0, 1'b0, 8'h5A, -1);
    bus(16'h0010, 1'b1, 1'b0, 8'h00, -1);
    bus(16'h0200, 1'b1, 1'b1, 8'h00, -1);
    bus(16'hFFFE, 1'b1, 1'b0, 8'h00, -1);
    bus(16'hFFFF, 1'b1, 1'b0, 8'h00, -1);
    bus(16'hFFFC, 1'b0, 1'b0, 8'h12, -1);
    random_phase(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the 6502 core's external bus. It answers every CPU bus cycle (address, RWbar, sync), supplies read data on `din`, and commits writes. It throttles the core through READY using per-access-type wait states. It holds the bench RAM, the interrupt/reset vector bytes and a small MMIO block, and sits between the core and the testbench/top level.

## Interface
- `RAM_AW`, 12: RAM address width; RAM is 2^RAM_AW bytes at 0x0000 upward.
- `WAIT_FETCH`, 1: wait states for opcode fetch (read with `i_sync`=1).
- `WAIT_RD`, 0: wait states for all other reads.
- `WAIT_WR`, 0: wait states for writes.
- `RESET_VEC`, 16'h0200: value returned at 0xFFFC/0xFFFD (lo/hi).
- `NMI_VEC`, 16'h0300: value at 0xFFFA/0xFFFB.
- `IRQ_VEC`, 16'h0400: value at 0xFFFE/0xFFFF.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_addr`  in  16  CPU address, held by the CPU while `o_ready`=0.
- `i_dout`  in  8  CPU write data.
- `i_rwbar`  in  1  1 = read, 0 = write.
- `i_sync`  in  1  opcode-fetch cycle marker.
- `o_din`  out  8  read data to the CPU `din`.
- `o_ready`  out  1  READY to the CPU; 1 = current bus cycle completes at this edge.
- `o_port`  out  8  MMIO output port register.
- `o_port_stb`  out  1  one-cycle pulse when the port is written.
- `o_bus_err`  out  1  one-cycle pulse on an unmapped write.
- `i_ld_en`  in  1  bench preload write enable.
- `i_ld_addr`  in  RAM_AW  preload address.
- `i_ld_data`  in  8  preload data.

## Operation
- Address map:
  - `addr < 2^RAM_AW`: RAM.
  - 0xF000: port; a read returns `o_port`.
  - 0xF001: read-only 8-bit free-running cycle counter.
  - 0xFFFA–0xFFFF: vector bytes, little-endian, read-only.
  - Everything else is unmapped. Unmapped reads return 0xFF. Writes to unmapped or read-only locations are dropped and pulse `o_bus_err`.
- Wait-state FSM, 2 states, plus a counter `cnt` of width clog2(max wait + 1):
  - FIRST (new bus cycle): w = WAIT_FETCH if `i_rwbar`&`i_sync`, WAIT_RD if `i_rwbar`, else WAIT_WR.
    - If w==0: `o_ready`=1, the access completes, stay in FIRST.
    - Otherwise: `o_ready`=0, `cnt`<=w-1, go to HOLD.
  - HOLD: `o_ready`=(`cnt`==0).
    - If `cnt`==0: the access completes, go to FIRST.
    - Otherwise: `cnt`<=`cnt`-1.
- Access type is re-evaluated only in FIRST. Changes to `i_addr`/`i_rwbar` during HOLD are protocol violations; behaviour is don't-care.
- Read data: `o_din` is combinational from `i_addr` (asynchronous RAM read) when `o_ready`=1, and 0xFF when `o_ready`=0.
- Write commit: happens only at the rising edge where `o_ready`=1 and `i_rwbar`=0. RAM takes `i_dout`. A port write loads `o_port` and pulses `o_port_stb` for the following cycle.
- Preload: when `i_ld_en`=1, RAM[`i_ld_addr`]<=`i_ld_data` every edge, independent of the FSM. If a CPU write hits the same address in the same edge, the preload wins.
- Cycle counter: increments every edge and wraps 0xFF→0x00. The value read is the pre-edge value.
- Reset (asynchronous, any time, including mid-HOLD):
  - State→FIRST, `cnt`=0, `o_port`=0, counter=0, `o_port_stb`=0, `o_bus_err`=0.
  - While `i_rst_n`=0: `o_ready`=0 and `o_din`=0xFF.
  - RAM contents are not cleared. An in-flight write is aborted and not committed.

## Timing
- An access with w wait states completes on its (w+1)th cycle: `o_ready` is low for exactly w cycles, then high for 1.
- Back-to-back zero-wait accesses keep `o_ready`=1 continuously.
- `o_port_stb` and `o_bus_err` are registered: high for exactly 1 cycle, in the cycle after the committing edge.
- First bus cycle after reset release is evaluated in FIRST on the first edge with `i_rst_n`=1.
- Read-after-write to the same RAM address in the next bus cycle returns the new data.

## Test plan
- Reset-vector fetch, defaults: release reset, read 0xFFFC then 0xFFFD → `o_din` = 0x00 then 0x02, `o_ready`=1 both cycles.
- Fetch wait states: `i_sync`=1 read of 0x0200 preloaded with 0xA9, WAIT_FETCH=1 → `o_ready` 0 for 1 cycle with `o_din`=0xFF, then 1 with `o_din`=0xA9. Repeat with WAIT_FETCH=3 → 3 low cycles.
- Write/readback: write 0x5A to 0x0010 with WAIT_WR=2 → RAM unchanged until the 3rd cycle edge. The next read of 0x0010 returns 0x5A.
- MMIO: write 0x3C to 0xF000 → `o_port`=0x3C and a 1-cycle `o_port_stb`. Reading 0xF000 returns 0x3C. Writing 0x8000 → `o_bus_err` pulse, and reading 0x8000 returns 0xFF.
- Reset mid-operation: WAIT_WR=3, assert `i_rst_n` low during the second HOLD cycle of a write to 0x0020 (old value 0x11) → `o_ready`=0 immediately, 0x0020 still reads 0x11 after release, `o_port`=0.
- Preload collision: `i_ld_en` writes 0x77 to 0x0030 at the same edge a CPU write of 0x99 to 0x0030 commits → 0x0030 reads 0x77.
